bg_mem_sched: RTL

Scheduler and arbiter for the single-port background image memory read by `draw_bg`. During active video it generates the scaled display read address each cycle. It uses incremental counters rather than dividers. During blanking it grants a background loader (screen switcher, UART loader) write access through a valid/ready handshake. A guard window ensures that no write can collide with the first display read of a line.

---
 rtl/bg_mem_sched.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bg_mem_sched.sv
// bg_mem_sched
//   Scheduler/arbiter for the single-port background image memory.
//   Active video: issues one scaled display read address per pixel clock,
//   derived from incremental texel counters (no multiply/divide).
//   Blanking: grants a background loader write access, except during the
//   last GUARD cycles of each line so the first display read of the next
//   line can never collide with a write.
//
// Ports
//   clk, rst_n          pixel clock, synchronous active-low reset
//   hcount, vcount      VGA timing position
//   hblnk, vblnk        VGA blanking flags
//   mem_addr/we/wdata   registered memory port (read or write)
//   pix_valid           registered, mem_addr is an in-range display read
//   ld_valid/addr/data  loader write request
//   ld_ready            combinational grant
//   ld_err              one-cycle pulse for an accepted out-of-range write
//
// Loader handshake: a write transfers in every cycle where
// ld_valid && ld_ready. While ld_ready is low the loader holds ld_valid,
// ld_addr and ld_data stable. ld_ready depends only on timing inputs and
// rst_n, never on ld_valid.
module bg_mem_sched #(
  parameter int IMAGE_WIDTH  = 64,
  parameter int IMAGE_HEIGHT = 48,
  parameter int SCALE        = 13,
  parameter int ADDR_W       = 12,
  parameter int H_TOTAL      = 1056,
  parameter int GUARD        = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [10:0]       hcount,
  input  logic [10:0]       vcount,
  input  logic              hblnk,
  input  logic              vblnk,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [11:0]       mem_wdata,
  output logic              pix_valid,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [11:0]       ld_data,
  output logic              ld_ready,
  output logic              ld_err
);

  localparam int XS_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [XS_W-1:0]   SUB_LAST = XS_W'(SCALE - 1);
  localparam logic [10:0]       WR_END   = 11'(H_TOTAL - GUARD);
  localparam logic [10:0]       IW_L     = 11'(IMAGE_WIDTH);
  localparam logic [10:0]       IH_L     = 11'(IMAGE_HEIGHT);
  localparam logic [ADDR_W-1:0] IW_A     = ADDR_W'(IMAGE_WIDTH);
  localparam logic [ADDR_W:0]   NPIX_L   = (ADDR_W + 1)'(IMAGE_WIDTH * IMAGE_HEIGHT);

  typedef enum logic [1:0] {
    S_DISP     = 2'd0,
    S_BLANK_WR = 2'd1,
    S_GUARD    = 2'd2
  } state_e;

  state_e state_d, state_q;

  logic [XS_W-1:0]   x_sub_q, y_sub_q;
  logic [10:0]       x_idx_q, y_idx_q;
  logic [ADDR_W-1:0] row_base_q;

  logic              ld_fire, ld_in_range, hblnk_rise, rd_in_range;
  logic [ADDR_W-1:0] rd_addr;

  // vcount is not needed: vertical position is tracked by counting lines.
  logic unused_vcount;
  assign unused_vcount = ^vcount;

  // State follows the current timing inputs every cycle.
  always_comb begin
    state_d = S_DISP;
    if (hblnk || vblnk) begin
      state_d = (hcount < WR_END) ? S_BLANK_WR : S_GUARD;
    end
  end

  assign ld_ready    = rst_n && (state_d == S_BLANK_WR);
  assign ld_fire     = ld_valid && ld_ready;
  assign ld_in_range = {1'b0, ld_addr} < NPIX_L;
  // Active video is always followed directly by hblnk within a line, so
  // "last cycle was DISP and hblnk is now high" marks the end of a line.
  assign hblnk_rise  = hblnk && (state_q == S_DISP);
  assign rd_in_range = (x_idx_q < IW_L) && (y_idx_q < IH_L);
  assign rd_addr     = row_base_q + ADDR_W'(x_idx_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_DISP;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      pix_valid  <= 1'b0;
      ld_err     <= 1'b0;
      x_sub_q    <= '0;
      x_idx_q    <= '0;
      y_sub_q    <= '0;
      y_idx_q    <= '0;
      row_base_q <= '0;
    end else begin
      state_q   <= state_d;
      mem_we    <= 1'b0;
      pix_valid <= 1'b0;
      ld_err    <= 1'b0;

      case (state_d)
        S_DISP: begin
          pix_valid <= rd_in_range;
          mem_addr  <= rd_in_range ? rd_addr : '0;
          if (x_sub_q == SUB_LAST) begin
            x_sub_q <= '0;
            x_idx_q <= x_idx_q + 11'd1;
          end else begin
            x_sub_q <= x_sub_q + 1'b1;
          end
        end
        S_BLANK_WR: begin
          if (ld_fire) begin
            if (ld_in_range) begin
              mem_we    <= 1'b1;
              mem_addr  <= ld_addr;
              mem_wdata <= ld_data;
            end else begin
              // Consumed but dropped; the loader is told via ld_err.
              ld_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (hblnk_rise) begin
        x_sub_q <= '0;
        x_idx_q <= '0;
      end

      if (vblnk) begin
        y_sub_q    <= '0;
        y_idx_q    <= '0;
        row_base_q <= '0;
      end else if (hblnk_rise) begin
        if (y_sub_q == SUB_LAST) begin
          y_sub_q    <= '0;
          y_idx_q    <= y_idx_q + 11'd1;
          row_base_q <= row_base_q + IW_A;
        end else begin
          y_sub_q <= y_sub_q + 1'b1;
        end
      end
    end
  end

endmodule
